// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped data cache controller:
// FSM state encoding and the fixed address-field geometry.
package dcache_ctrl_pkg;

  // Address geometry: tag[7:5], index[4:2], offset[1:0]
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 8;

  // Controller states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_FETCH     = 2'd2;

endpackage

// File: rtl/dcache_byte_sel.sv
// Byte lane helper for a 4-byte cache block: selects the load byte named
// by the offset, and builds the block with the store byte merged in.
// Byte n of the block lives in bits [8n+7:8n].
module dcache_byte_sel
  import dcache_ctrl_pkg::*;
(
  input  logic [31:0]         line_data,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [7:0]          wr_byte,
  output logic [7:0]          rd_byte,
  output logic [31:0]         merged
);

  // 4:1 read mux and single-byte write merge, both steered by the offset
  always_comb begin
    rd_byte = line_data[7:0];
    merged  = line_data;
    case (offset)
      2'd0: begin
        rd_byte      = line_data[7:0];
        merged[7:0]  = wr_byte;
      end
      2'd1: begin
        rd_byte      = line_data[15:8];
        merged[15:8] = wr_byte;
      end
      2'd2: begin
        rd_byte       = line_data[23:16];
        merged[23:16] = wr_byte;
      end
      default: begin
        rd_byte       = line_data[31:24];
        merged[31:24] = wr_byte;
      end
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller:
// 8 lines of 4 bytes, 8-bit byte address.
//
// Handshakes: the CPU holds READ or WRITE (with ADDRESS/WRITEDATA stable)
// and the access is taken on the rising edge where BUSYWAIT is low. The
// controller holds MEM_READ or MEM_WRITE (with MEM_ADDRESS/MEM_WRITEDATA
// stable) and a block transfer completes on the rising edge where
// MEM_BUSYWAIT is low.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [7:0]                 ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0]   MEM_ADDRESS,
  output logic [31:0]                MEM_WRITEDATA,
  input  logic [31:0]                MEM_READDATA,
  input  logic                       MEM_BUSYWAIT,
  output logic [1:0]                 dbg_state
);

  logic [1:0]               state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [LINES-1:0]         dirty_q, dirty_d;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [TAG_W-1:0]         tag_d  [LINES];
  logic [31:0]              data_q [LINES];
  logic [31:0]              data_d [LINES];
  logic [7:0]               readdata_q, readdata_d;
  // Block address of the miss being serviced; held so the fill still lands
  // correctly if the CPU drops its request mid-miss.
  logic [TAG_W+INDEX_W-1:0] miss_addr_q, miss_addr_d;

  logic [TAG_W-1:0]         addr_tag;
  logic [INDEX_W-1:0]       addr_idx;
  logic [OFFSET_W-1:0]      addr_off;
  logic [INDEX_W-1:0]       miss_idx;
  logic [TAG_W-1:0]         miss_tag;
  logic                     idle;
  logic                     hit;
  logic                     rd_hit;
  logic                     wr_hit;
  logic [7:0]               sel_byte;
  logic [31:0]              merged_line;

  assign addr_tag  = ADDRESS[7:5];
  assign addr_idx  = ADDRESS[4:2];
  assign addr_off  = ADDRESS[1:0];
  assign miss_idx  = miss_addr_q[INDEX_W-1:0];
  assign miss_tag  = miss_addr_q[TAG_W+INDEX_W-1:INDEX_W];
  assign dbg_state = state_q;

  dcache_byte_sel u_byte_sel (
    .line_data (data_q[addr_idx]),
    .offset    (addr_off),
    .wr_byte   (WRITEDATA),
    .rd_byte   (sel_byte),
    .merged    (merged_line)
  );

  // Hit detection, CPU-side outputs, FSM next state and line updates
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    data_d        = data_q;
    miss_addr_d   = miss_addr_q;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;

    idle   = (state_q == ST_IDLE);
    hit    = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    rd_hit = idle && READ && hit;
    // A simultaneous READ wins; the store is dropped.
    wr_hit = idle && WRITE && !READ && hit;

    BUSYWAIT   = (READ || WRITE) && !(idle && hit);
    READDATA   = rd_hit ? sel_byte : readdata_q;
    readdata_d = READDATA;

    case (state_q)
      ST_IDLE: begin
        if ((READ || WRITE) && !hit) begin
          miss_addr_d = ADDRESS[7:2];
          if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FETCH;
          end
        end
        if (wr_hit) begin
          data_d[addr_idx]  = merged_line;
          dirty_d[addr_idx] = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[miss_idx], miss_idx};
        MEM_WRITEDATA = data_q[miss_idx];
        if (!MEM_BUSYWAIT) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = miss_addr_q;
        if (!MEM_BUSYWAIT) begin
          data_d[miss_idx]  = MEM_READDATA;
          tag_d[miss_idx]   = miss_tag;
          valid_d[miss_idx] = 1'b1;
          dirty_d[miss_idx] = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset invalidates every line and drops any transfer
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      readdata_q  <= '0;
      miss_addr_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      readdata_q  <= readdata_d;
      miss_addr_q <= miss_addr_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have no parameters; geometry SHALL be fixed: 8 lines, 4-byte blocks, direct-mapped, 8-bit byte address.
REQ-002 CLK  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 READ  input  1  CPU load request, held until BUSYWAIT is low.
REQ-005 WRITE  input  1  CPU store request, held until BUSYWAIT is low.
REQ-006 ADDRESS  input  8  byte address from the ALU RESULT: tag[7:5], index[4:2], offset[1:0].
REQ-007 WRITEDATA  input  8  store byte from register file.
REQ-008 READDATA  output  8  load byte to register file write-back.
REQ-009 BUSYWAIT  output  1  CPU stall; PC and register file SHALL hold while it is high.
REQ-010 MEM_READ  output  1  block fetch request to data memory.
REQ-011 MEM_WRITE  output  1  block write-back request to data memory.
REQ-012 MEM_ADDRESS  output  6  block address {tag,index}.
REQ-013 MEM_WRITEDATA  output  32  block write data; byte n SHALL be bits [8n+7:8n].
REQ-014 MEM_READDATA  input  32  fetched block.
REQ-015 MEM_BUSYWAIT  input  1  memory busy; a transfer SHALL complete on the first rising edge at which it is low while its request is asserted.

Function
REQ-016 Per line state SHALL be: valid(1), dirty(1), tag(3), data(32).
REQ-017 Hit SHALL be: valid[index] and tag[index]==ADDRESS[7:5], evaluated combinationally in IDLE.
REQ-018 FSM states SHALL be IDLE, WRITEBACK, FETCH.
REQ-019 IDLE→WRITEBACK: on a miss (READ or WRITE) with the victim line valid and dirty.
REQ-020 IDLE→FETCH: on a miss with the victim line clean or invalid.
REQ-021 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim data; on completion the FSM SHALL go to FETCH.
REQ-022 FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]; on completion the line SHALL load MEM_READDATA, tag=ADDRESS[7:5], valid=1, dirty=0, and the FSM SHALL go to IDLE.
REQ-023 A request SHALL always hit in IDLE on the cycle after FETCH completes.
REQ-024 BUSYWAIT SHALL be (READ|WRITE) and not (state==IDLE and hit), combinational.
REQ-025 A read hit SHALL drive READDATA with the byte selected by the offset in the same cycle, with zero extra latency.
REQ-026 READDATA SHALL hold its last value when no read hit is present.
REQ-027 A write hit SHALL update the byte selected by the offset and set dirty=1 at the rising edge; no memory traffic SHALL occur.
REQ-028 If READ and WRITE are both high, READ SHALL take priority and WRITE SHALL be ignored.
REQ-029 MEM_READ and MEM_WRITE SHALL never both be high, and both SHALL be low in IDLE.
REQ-030 A request deasserted mid-miss SHALL still complete the in-flight transfer; the line fill SHALL proceed.

Reset
REQ-031 RESET low SHALL immediately force state=IDLE, all valid=0, all dirty=0, READDATA=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, and MEM_WRITEDATA=0.
REQ-032 Reset mid-WRITEBACK or mid-FETCH SHALL abandon the transfer with no line update; tag and data arrays need not be cleared.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, WRITEBACK=2'd1, FETCH=2'd2) and the field widths TAG_W=3, INDEX_W=3, OFFSET_W=2, LINES=8.
REQ-034 One sub-module, dcache_byte_sel, SHALL implement the 4:1 byte read mux and the byte-enable write merge.

Verification
REQ-035 Cold read of 0x24 with memory busy for 5 cycles → FETCH with MEM_ADDRESS=0x09; BUSYWAIT high for 6 cycles; then READDATA equals byte 0 of memory block 0x09.
REQ-036 Write 0xAB to 0x25 after REQ-035 → BUSYWAIT never high, no MEM_* activity; a following read of 0x25 returns 0xAB with line 1 dirty.
REQ-037 Read of 0xA4 (same index 1, tag 5) after REQ-036 → WRITEBACK to MEM_ADDRESS=0x09 with byte 1=0xAB, then FETCH from 0x29, then a hit.
REQ-038 READ and WRITE both high at 0x24 on a hit → READDATA valid and line data unchanged.
REQ-039 RESET pulsed low during FETCH → MEM_READ drops without waiting for a clock, state=IDLE, and the next read of 0x24 misses.
REQ-040 Back-to-back read hits on offsets 0–3 of one line → four distinct bytes returned in four consecutive cycles with BUSYWAIT low throughout.
